// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the MEM pipeline stage.
//   - reset / stall / zero-word constants
//   - aluop codes of the memory instructions
//   - FSM state encoding and the captured-operation record
//   - helpers that classify an aluop and build bus lane selects / store data
package mem_access_pkg;

    localparam logic        RST_ENABLE = 1'b0;   // rst is active-low
    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam int          STALL_MEM  = 3;      // MEM-stage bit of the stall vector

    localparam logic [7:0] ALU_LB  = 8'hE0;
    localparam logic [7:0] ALU_LBU = 8'hE4;
    localparam logic [7:0] ALU_LH  = 8'hE1;
    localparam logic [7:0] ALU_LHU = 8'hE5;
    localparam logic [7:0] ALU_LW  = 8'hE3;
    localparam logic [7:0] ALU_SB  = 8'hE8;
    localparam logic [7:0] ALU_SH  = 8'hE9;
    localparam logic [7:0] ALU_SW  = 8'hEB;
    localparam logic [7:0] ALU_LL  = 8'hF0;
    localparam logic [7:0] ALU_SC  = 8'hF8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Everything the write-back bundle needs once the live inputs move on.
    typedef struct packed {
        logic [7:0]  aluop;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  addr_lo;
    } op_t;

    function automatic logic is_byte(input logic [7:0] aluop);
        return (aluop == ALU_LB) || (aluop == ALU_LBU) || (aluop == ALU_SB);
    endfunction

    function automatic logic is_half(input logic [7:0] aluop);
        return (aluop == ALU_LH) || (aluop == ALU_LHU) || (aluop == ALU_SH);
    endfunction

    function automatic logic is_word(input logic [7:0] aluop);
        return (aluop == ALU_LW) || (aluop == ALU_SW) ||
               (aluop == ALU_LL) || (aluop == ALU_SC);
    endfunction

    function automatic logic is_store(input logic [7:0] aluop);
        return (aluop == ALU_SB) || (aluop == ALU_SH) ||
               (aluop == ALU_SW) || (aluop == ALU_SC);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] aluop);
        return is_byte(aluop) || is_half(aluop) || is_word(aluop);
    endfunction

    function automatic logic is_load(input logic [7:0] aluop);
        return is_mem_op(aluop) && !is_store(aluop);
    endfunction

    // Big-endian lanes: byte address 0 lives in bits [31:24].
    function automatic logic [3:0] lane_sel(input logic [7:0] aluop,
                                            input logic [1:0] addr_lo);
        logic [3:0] sel;
        sel = 4'b1111;
        if (is_byte(aluop))
            sel = 4'b1000 >> addr_lo;
        else if (is_half(aluop))
            sel = addr_lo[1] ? 4'b0011 : 4'b1100;
        return sel;
    endfunction

    // Narrow stores replicate their data so every selected lane sees it.
    function automatic logic [31:0] store_data(input logic [7:0]  aluop,
                                               input logic [31:0] reg2);
        logic [31:0] data;
        data = reg2;
        if (is_byte(aluop))
            data = {4{reg2[7:0]}};
        else if (is_half(aluop))
            data = {2{reg2[15:0]}};
        return data;
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// mem_load_ext: picks the addressed big-endian lane out of a bus read word
// and sign- or zero-extends it according to the load opcode.
// Ports:
//   aluop    in  8   load opcode
//   addr_lo  in  2   low effective-address bits
//   rdata    in  32  captured bus read data
//   result   out 32  value written to the GPR
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path can infer a latch.
        byte_lane = rdata[31:24];
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        result    = ZERO_WORD;

        case (addr_lo)
            2'b01:   byte_lane = rdata[23:16];
            2'b10:   byte_lane = rdata[15:8];
            2'b11:   byte_lane = rdata[7:0];
            default: byte_lane = rdata[31:24];
        endcase

        case (aluop)
            ALU_LB:         result = {{24{byte_lane[7]}}, byte_lane};
            ALU_LBU:        result = {24'h0, byte_lane};
            ALU_LH:         result = {{16{half_lane[15]}}, half_lane};
            ALU_LHU:        result = {16'h0, half_lane};
            ALU_LW, ALU_LL: result = rdata;
            default:        result = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Runs loads/stores/ll/sc over a handshaked
// data bus, stalls the pipeline while a transaction is outstanding and
// produces the write-back bundle registered by mem_wb.
// Optional macro MEM_ALIGN_CHECK_EN: adds the misalign output and suppresses
// bus access for misaligned half/word operations. Without it the low address
// bits of half/word operations are simply ignored.
// Ports:
//   clk, rst (async, active-low)
//   stall[5:0]                 pipeline stall vector, bit 3 = MEM
//   wd_i, wreg_i, wdata_i      GPR destination / enable / ALU result
//   aluop_i, mem_addr_i        operation and effective address
//   reg2_i                     store data / rt value
//   whilo_i, hi_i, lo_i        HI/LO write-back
//   llbit_i                    committed LLbit
//   wb_llbit_we/value          LLbit being written in WB (forwarded)
//   dbus_req/we/addr/sel/wdata registered bus request
//   dbus_rdata, dbus_ack       bus response
//   mem_*                      write-back bundle to mem_wb
//   stallreq                   stall request to pipeline control
//   misalign                   (MEM_ALIGN_CHECK_EN only) misaligned access
module mem_access
    import mem_access_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall,
    input  logic [4:0]    wd_i,
    input  logic          wreg_i,
    input  logic [31:0]   wdata_i,
    input  logic [7:0]    aluop_i,
    input  logic [31:0]   mem_addr_i,
    input  logic [31:0]   reg2_i,
    input  logic          whilo_i,
    input  logic [31:0]   hi_i,
    input  logic [31:0]   lo_i,
    input  logic          llbit_i,
    input  logic          wb_llbit_we,
    input  logic          wb_llbit_value,
    output logic          dbus_req,
    output logic          dbus_we,
    output logic [AW-1:0] dbus_addr,
    output logic [3:0]    dbus_sel,
    output logic [DW-1:0] dbus_wdata,
    input  logic [DW-1:0] dbus_rdata,
    input  logic          dbus_ack,
    output logic [4:0]    mem_wd,
    output logic          mem_wreg,
    output logic [31:0]   mem_wdata,
    output logic          mem_whilo,
    output logic [31:0]   mem_hi,
    output logic [31:0]   mem_lo,
    output logic          mem_llbit_we,
    output logic          mem_llbit_value,
    output logic          stallreq
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic          misalign
`endif
);

    state_e      state;
    op_t         op_q;
    logic [31:0] rdata_q;

    op_t         op_live;
    op_t         op_cur;
    logic        llbit_eff;
    logic        misaligned;
    logic        sc_fail;
    logic        start;
    logic [31:0] load_data;

    // Only the MEM bit of the stall vector matters to this stage.
    logic        unused_stall;
    assign unused_stall = ^{stall[5:4], stall[2:0]};

    assign op_live = '{aluop:   aluop_i,
                       wd:      wd_i,
                       wreg:    wreg_i,
                       wdata:   wdata_i,
                       whilo:   whilo_i,
                       hi:      hi_i,
                       lo:      lo_i,
                       addr_lo: mem_addr_i[1:0]};

    // Once a transaction is launched the bundle describes the launched op.
    assign op_cur    = (state == ST_IDLE) ? op_live : op_q;

    // A write-back of LLbit in flight overrides the committed copy.
    assign llbit_eff = wb_llbit_we ? wb_llbit_value : llbit_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (is_half(aluop_i) && mem_addr_i[0]) ||
                        (is_word(aluop_i) && (mem_addr_i[1:0] != 2'b00));
    assign misalign   = (rst != RST_ENABLE) && (state == ST_IDLE) && misaligned;
`else
    assign misaligned = 1'b0;
`endif

    // A failing sc resolves locally, so it never touches the bus.
    assign sc_fail = (aluop_i == ALU_SC) && !llbit_eff;
    assign start   = (state == ST_IDLE) && is_mem_op(aluop_i) && !sc_fail && !misaligned;

    mem_load_ext u_load_ext (
        .aluop   (op_cur.aluop),
        .addr_lo (op_cur.addr_lo),
        .rdata   (rdata_q),
        .result  (load_data)
    );

    always_comb begin
        mem_wd          = 5'd0;
        mem_wreg        = 1'b0;
        mem_wdata       = ZERO_WORD;
        mem_whilo       = 1'b0;
        mem_hi          = ZERO_WORD;
        mem_lo          = ZERO_WORD;
        mem_llbit_we    = 1'b0;
        mem_llbit_value = 1'b0;
        stallreq        = 1'b0;

        if (rst != RST_ENABLE) begin
            mem_wd    = op_cur.wd;
            mem_wreg  = op_cur.wreg;
            mem_wdata = op_cur.wdata;
            mem_whilo = op_cur.whilo;
            mem_hi    = op_cur.hi;
            mem_lo    = op_cur.lo;

            if (is_load(op_cur.aluop))
                mem_wdata = load_data;

            if (op_cur.aluop == ALU_LL) begin
                mem_llbit_we    = 1'b1;
                mem_llbit_value = 1'b1;
            end

            // A captured sc only exists because LLbit was set when it launched.
            if (op_cur.aluop == ALU_SC) begin
                if ((state != ST_IDLE) || llbit_eff) begin
                    mem_wdata       = 32'd1;
                    mem_llbit_we    = 1'b1;
                    mem_llbit_value = 1'b0;
                end else begin
                    mem_wdata = ZERO_WORD;
                end
            end

            if ((state == ST_IDLE) && misaligned) begin
                mem_wreg        = 1'b0;
                mem_wdata       = wdata_i;
                mem_llbit_we    = 1'b0;
                mem_llbit_value = 1'b0;
            end

            stallreq = start || (state == ST_BUSY);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            rdata_q    <= ZERO_WORD;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_sel   <= 4'b0000;
            dbus_wdata <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store(aluop_i);
                        dbus_addr  <= {mem_addr_i[AW-1:2], 2'b00};
                        dbus_sel   <= lane_sel(aluop_i, mem_addr_i[1:0]);
                        dbus_wdata <= store_data(aluop_i, reg2_i);
                        op_q       <= op_live;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        rdata_q  <= dbus_rdata;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // mem_wb captures the bundle on the same edge we leave DONE.
                    if (stall[STALL_MEM] == NO_STOP)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage between the EX/MEM register and mem_wb.
- Drives a handshaked data bus for loads, stores, ll and sc. Byte/halfword lanes are big-endian.
- Raises stallreq while a bus transaction is outstanding.
- Produces the mem_* write-back bundle (GPR, HI/LO, LLbit) that mem_wb registers.

Parameters:
- AW, 32, data-bus address width.
- DW, 32, data-bus data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- stall  in  6  pipeline stall vector; bit 3 = MEM stage
- wd_i  in  5  destination register address
- wreg_i  in  1  GPR write enable
- wdata_i  in  32  ALU result
- aluop_i  in  8  operation code
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data / rt value
- whilo_i  in  1  HI/LO write enable
- hi_i  in  32  HI value
- lo_i  in  32  LO value
- llbit_i  in  1  committed LLbit
- wb_llbit_we  in  1  LLbit write in WB (forwarding)
- wb_llbit_value  in  1  LLbit value in WB (forwarding)
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  bus write enable, registered
- dbus_addr  out  32  word-aligned address, registered
- dbus_sel  out  4  byte-lane select, registered
- dbus_wdata  out  32  bus write data, registered
- dbus_rdata  in  32  bus read data
- dbus_ack  in  1  bus acknowledge
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- mem_whilo  out  1  to mem_wb
- mem_hi  out  32  to mem_wb
- mem_lo  out  32  to mem_wb
- mem_llbit_we  out  1  to mem_wb
- mem_llbit_value  out  1  to mem_wb
- stallreq  out  1  to pipeline control

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0, rdata_q=0.
  - Combinational outputs are zero while rst=0; stallreq=0.
  - Reset during BUSY drops dbus_req immediately; the transaction is abandoned.
- Non-memory ops: zero-latency pass-through of wd/wreg/wdata/whilo/hi/lo; llbit_we=0; stallreq=0.
- LLbit effective value = wb_llbit_we ? wb_llbit_value : llbit_i.
- State machine:
  - IDLE:
    - A memory op is present → stallreq=1 combinationally.
    - Exception: sc with LLbit=0 completes without the bus, so stallreq=0 for it.
    - On the clock edge: load dbus_* registers, dbus_req=1, go to BUSY.
  - BUSY:
    - stallreq=1; dbus_* held stable until dbus_ack.
    - On ack: dbus_req=0; capture dbus_rdata into rdata_q; go to DONE.
    - An ack in the same cycle the request first rises is legal; completion takes at least 2 cycles.
  - DONE:
    - stallreq=0; outputs present the final result.
    - When stall[3]=NoStop, return to IDLE on the next edge; mem_wb captures on that same edge.
    - When stall[3]=Stop (another stage stalls), hold DONE with outputs stable.
- Lane select (big-endian):
  - byte ops: addr[1:0]=00→1000, 01→0100, 10→0010, 11→0001.
  - half ops: addr[1]=0→1100, 1→0011.
  - word ops: 1111.
  - sb/sh replicate store data across lanes.
- Loads:
  - lb/lh sign-extend the selected lane; lbu/lhu zero-extend; lw/ll take the whole word.
  - ll additionally sets llbit_we=1, llbit_value=1.
- Stores: mem_wreg follows wreg_i; mem_wdata passes wdata_i.
- sc:
  - LLbit=1 → word store; on DONE, mem_wdata=1, llbit_we=1, llbit_value=0.
  - LLbit=0 → no bus access; same-cycle mem_wdata=0, llbit_we=0.
- While state≠IDLE, the bundle reflects the captured op, not the live inputs. The inputs are frozen by the stall in any case.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign (1 bit).
  - A half op with addr[0]=1, or a word op with addr[1:0]≠00, issues no bus access.
  - For such ops: misalign=1 for that cycle, mem_wreg=0, llbit_we=0, stallreq=0.
- Undefined: low address bits are ignored for half/word ops (forced aligned); no misalign port.

Decomposition:
- Shared define header holds:
  - aluop codes (LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC);
  - FSM state encodings (IDLE/BUSY/DONE);
  - Stop/NoStop, ZeroWord, RstEnable-style constants.
- Sub-module mem_load_ext: combinational lane extract and sign/zero extension (aluop, addr[1:0], rdata → 32-bit result).

Test Plan:
- lb at addr 0x...01, bus returns 0x12_80_34_56 after 3-cycle ack → dbus_sel=0100, stallreq high for 4 cycles, mem_wdata=0xFFFFFF80.
- sh with reg2_i=0x0000BEEF, addr 0x...02 → dbus_we=1, sel=0011, wdata=0xBEEFBEEF, mem_wreg=0 on completion.
- ll, then sc while wb_llbit_we=1/value=1 → sc stores; mem_wdata=1, llbit_we=1, llbit_value=0. Repeat with LLbit=0 → no dbus_req, mem_wdata=0, stallreq=0.
- Load completes into DONE while stall[3] is forced Stop for 2 cycles → outputs stable, no second dbus_req, IDLE after release.
- rst asserted mid-BUSY → dbus_req falls asynchronously; after release, an addu passes through with zero latency.
- With MEM_ALIGN_CHECK_EN: lw at addr 0x...02 → misalign=1, no bus request, mem_wreg=0.
